aes_decrypt_iter: RTL and testbench

AES_DECRYPT_ITER -- requirements
Module: aes_decrypt_iter

---
 rtl/aes_decrypt_iter.sv | 172 +++++++++++++++++
 tb/tb_aes_decrypt_iter.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_decrypt_iter.sv
// Iterative AES-128 inverse cipher, one round per clock.
// A block is accepted in IDLE (i_valid && o_ready); the initial AddRoundKey with rk10 happens
// on the accept edge, the next ten edges run the inverse rounds, and the result is held in DONE
// until the downstream handshake (i_ready while o_valid).
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   i_valid/o_ready input handshake; o_ready is high only in IDLE
//   i_cipher_text   ciphertext, byte 0 = bits 0:7
//   i_key_schedule  expanded encryption key, round key r = bits 128*r +: 128
//   i_phase         sideband tag carried with the block
//   o_valid/i_ready output handshake; o_valid is high only in DONE
//   o_plain_text    decrypted block
//   o_phase         tag of the block on o_plain_text
module aes_decrypt_iter #(
  parameter int unsigned NUM_ROUNDS = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_valid,
  output logic          o_ready,
  input  logic [0:127]  i_cipher_text,
  input  logic [0:1407] i_key_schedule,
  input  logic [0:2]    i_phase,
  output logic          o_valid,
  input  logic          i_ready,
  output logic [0:127]  o_plain_text,
  output logic [0:2]    o_phase
);

  localparam logic [3:0] LastRound = 4'(NUM_ROUNDS - 1);

  // Inverse S-box, entry x at bits 8*x +: 8.
  localparam logic [0:2047] InvSbox = {
    256'h52096ad53036a538bf40a39e81f3d7fb7ce339829b2fff87348e4344c4dee9cb,
    256'h547b9432a6c2233dee4c950b42fac34e082ea16628d924b2765ba2496d8bd125,
    256'h72f8f66486689816d4a45ccc5d65b6926c704850fdedb9da5e154657a78d9d84,
    256'h90d8ab008cbcd30af7e45805b8b34506d02c1e8fca3f0f02c1afbd0301138a6b,
    256'h3a9111414f67dcea97f2cfcef0b4e67396ac7422e7ad3585e2f937e81c75df6e,
    256'h47f11a711d29c5896fb7620eaa18be1bfc563e4bc6d279209adbc0fe78cd5af4,
    256'h1fdda8338807c731b11210592780ec5f60517fa919b54a0d2de57a9f93c99cef,
    256'ha0e03b4dae2af5b0c8ebbb3c83539961172b047eba77d626e169146355210c7d
  };

  typedef enum logic [1:0] {StIdle, StRound, StDone} state_e;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Multiply by a 4-bit constant (0x09, 0x0b, 0x0d, 0x0e) in GF(2^8), polynomial 0x11b.
  function automatic logic [7:0] gmul(input logic [7:0] b, input logic [3:0] m);
    logic [7:0] b2, b4, b8;
    b2 = xtime(b);
    b4 = xtime(b2);
    b8 = xtime(b4);
    return (m[0] ? b : 8'h00) ^ (m[1] ? b2 : 8'h00) ^ (m[2] ? b4 : 8'h00) ^
           (m[3] ? b8 : 8'h00);
  endfunction

  // Byte 4*c+r sits in column c, row r; row r rotates right by r columns.
  function automatic logic [0:127] inv_shift_rows(input logic [0:127] s);
    logic [0:127] r;
    for (int c = 0; c < 4; c++) begin
      for (int row = 0; row < 4; row++) begin
        r[8*(4*c+row) +: 8] = s[8*(4*((c - row + 4) % 4) + row) +: 8];
      end
    end
    return r;
  endfunction

  function automatic logic [0:127] inv_sub_bytes(input logic [0:127] s);
    logic [0:127] r;
    for (int i = 0; i < 16; i++) begin
      r[8*i +: 8] = InvSbox[{s[8*i +: 8], 3'b000} +: 8];
    end
    return r;
  endfunction

  function automatic logic [0:127] inv_mix_columns(input logic [0:127] s);
    logic [0:127] r;
    logic [7:0]   a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[32*c +: 8];
      a1 = s[32*c+8 +: 8];
      a2 = s[32*c+16 +: 8];
      a3 = s[32*c+24 +: 8];
      r[32*c +: 8]    = gmul(a0, 4'he) ^ gmul(a1, 4'hb) ^ gmul(a2, 4'hd) ^ gmul(a3, 4'h9);
      r[32*c+8 +: 8]  = gmul(a0, 4'h9) ^ gmul(a1, 4'he) ^ gmul(a2, 4'hb) ^ gmul(a3, 4'hd);
      r[32*c+16 +: 8] = gmul(a0, 4'hd) ^ gmul(a1, 4'h9) ^ gmul(a2, 4'he) ^ gmul(a3, 4'hb);
      r[32*c+24 +: 8] = gmul(a0, 4'hb) ^ gmul(a1, 4'hd) ^ gmul(a2, 4'h9) ^ gmul(a3, 4'he);
    end
    return r;
  endfunction

  state_e       st_q, st_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [0:127] blk_q, blk_d;
  logic [0:127] pt_d;
  logic [0:2]   ph_d;
  logic [0:2]   phase_q;
  logic [0:127] rk_q [NUM_ROUNDS];
  logic         load;
  logic [0:127] added;
  logic [0:127] mixed;

  assign added = inv_sub_bytes(inv_shift_rows(blk_q)) ^ rk_q[cnt_q];
  assign mixed = inv_mix_columns(added);

  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q;
    blk_d = blk_q;
    pt_d  = o_plain_text;
    ph_d  = o_phase;
    load  = 1'b0;
    unique case (st_q)
      StIdle: begin
        if (i_valid && o_ready) begin
          st_d  = StRound;
          cnt_d = LastRound;
          blk_d = i_cipher_text ^ i_key_schedule[128*NUM_ROUNDS +: 128];
          load  = 1'b1;
        end
      end
      StRound: begin
        if (cnt_q == 4'd0) begin
          // Final round has no InvMixColumns.
          pt_d = added;
          ph_d = phase_q;
          st_d = StDone;
        end else begin
          blk_d = mixed;
          cnt_d = cnt_q - 4'd1;
        end
      end
      StDone: begin
        if (i_ready) st_d = StIdle;
      end
      default: st_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q         <= StIdle;
      cnt_q        <= 4'd0;
      o_ready      <= 1'b1;
      o_valid      <= 1'b0;
      o_plain_text <= '0;
      o_phase      <= '0;
    end else begin
      st_q         <= st_d;
      cnt_q        <= cnt_d;
      o_ready      <= (st_d == StIdle);
      o_valid      <= (st_d == StDone);
      o_plain_text <= pt_d;
      o_phase      <= ph_d;
    end
  end

  // Working state and key latch never reach an output unqualified, so they carry no reset.
  always_ff @(posedge clk) begin
    blk_q <= blk_d;
    if (load) begin
      phase_q <= i_phase;
      for (int r = 0; r < int'(NUM_ROUNDS); r++) begin
        rk_q[r] <= i_key_schedule[128*r +: 128];
      end
    end
  end

endmodule

// File: tb/tb_aes_decrypt_iter.sv
// Self-checking bench for aes_decrypt_iter: FIPS-197 C.1 vector, backpressure, input
// disturbance, mid-operation reset, back-to-back throughput and a random round-trip against an
// independent forward-cipher model (S-box derived from the GF(2^8) inverse and affine map).
module tb_aes_decrypt_iter;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          i_valid = 1'b0;
  logic          o_ready;
  logic [0:127]  i_cipher_text = '0;
  logic [0:1407] i_key_schedule = '0;
  logic [0:2]    i_phase = '0;
  logic          o_valid;
  logic          i_ready = 1'b0;
  logic [0:127]  o_plain_text;
  logic [0:2]    o_phase;

  int checks = 0;
  int errors = 0;

  logic [7:0] sbox [256];

  aes_decrypt_iter #(.NUM_ROUNDS(10)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_valid       (i_valid),
    .o_ready       (o_ready),
    .i_cipher_text (i_cipher_text),
    .i_key_schedule(i_key_schedule),
    .i_phase       (i_phase),
    .o_valid       (o_valid),
    .i_ready       (i_ready),
    .o_plain_text  (o_plain_text),
    .o_phase       (o_phase)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [0:1407] expand(input logic [0:127] key);
    logic [31:0]   w [44];
    logic [31:0]   t;
    logic [7:0]    rc;
    logic [0:1407] ks;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[32*i +: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = {t[23:0], t[31:24]};
        t  = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
        rc = gm(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int i = 0; i < 44; i++) ks[32*i +: 32] = w[i];
    return ks;
  endfunction

  function automatic logic [0:127] aes_enc(input logic [0:127] pt, input logic [0:1407] ks);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [0:127] v;
    v = pt ^ ks[0 +: 128];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) s[i] = sbox[v[8*i +: 8]];
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++) t[4*c+row] = s[4*((c + row) % 4) + row];
      if (r != 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
          t[4*c]   = gm(a0, 8'h02) ^ gm(a1, 8'h03) ^ a2 ^ a3;
          t[4*c+1] = a0 ^ gm(a1, 8'h02) ^ gm(a2, 8'h03) ^ a3;
          t[4*c+2] = a0 ^ a1 ^ gm(a2, 8'h02) ^ gm(a3, 8'h03);
          t[4*c+3] = gm(a0, 8'h03) ^ a1 ^ a2 ^ gm(a3, 8'h02);
        end
      end
      for (int i = 0; i < 16; i++) v[8*i +: 8] = t[i];
      v = v ^ ks[128*r +: 128];
    end
    return v;
  endfunction

  function automatic logic [0:127] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic logic [0:1407] rand_ks();
    logic [0:1407] k;
    for (int i = 0; i < 44; i++) k[32*i +: 32] = $urandom();
    return k;
  endfunction

  task automatic issue(input logic [0:127] ct, input logic [0:1407] ks, input logic [0:2] ph);
    i_cipher_text  = ct;
    i_key_schedule = ks;
    i_phase        = ph;
    i_valid        = 1'b1;
    tick();
    i_valid        = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (o_valid !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic handshake();
    i_ready = 1'b1;
    tick();
    i_ready = 1'b0;
  endtask

  logic [0:127]  c1_key, c1_pt, c1_ct, key, pt, ct;
  logic [0:1407] c1_ks, ks;
  logic [0:127]  b_ct [4];
  logic [0:127]  b_pt [4];
  logic [0:1407] b_ks [4];
  logic [0:2]    b_ph [4];
  int            acc_at [4];
  int            n, k, got, guard;
  logic          flag, was_ready;
  logic [7:0]    inv;

  initial begin
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^
                {inv[3:0], inv[7:4]} ^ 8'h63;
    end
    c1_key = 128'h000102030405060708090a0b0c0d0e0f;
    c1_pt  = 128'h00112233445566778899aabbccddeeff;
    c1_ct  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    c1_ks  = expand(c1_key);
    check("model_rk10", c1_ks[1280 +: 128], 128'h13111d7fe3944a17f307a78b4d2b30c5);
    check("model_c1_enc", aes_enc(c1_pt, c1_ks), c1_ct);

    // Reset state
    #1 rst_n = 1'b0;
    #1;
    check("rst_ready", o_ready, 1'b1);
    check("rst_valid", o_valid, 1'b0);
    check("rst_pt", o_plain_text, '0);
    check("rst_phase", o_phase, '0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;

    // C.1 vector, latency, then 20 cycles of backpressure
    issue(c1_ct, c1_ks, 3'b101);
    check("c1_ready_after_accept", o_ready, 1'b0);
    wait_valid(n);
    check("c1_latency", n, 10);
    check("c1_pt", o_plain_text, c1_pt);
    check("c1_phase", o_phase, 3'b101);
    flag = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      flag &= (o_valid === 1'b1) && (o_ready === 1'b0) && (o_plain_text === c1_pt) &&
              (o_phase === 3'b101);
    end
    check("bp_stable", flag, 1'b1);
    handshake();
    check("hs_valid_low", o_valid, 1'b0);
    check("hs_ready_high", o_ready, 1'b1);

    // Inputs disturbed every cycle after accept, i_valid held high
    i_cipher_text  = c1_ct;
    i_key_schedule = c1_ks;
    i_phase        = 3'b101;
    i_valid        = 1'b1;
    tick();
    flag = 1'b1;
    n    = 0;
    while (o_valid !== 1'b1 && n < 40) begin
      flag &= (o_ready === 1'b0);
      i_cipher_text  = rand128();
      i_key_schedule = rand_ks();
      i_phase        = 3'($urandom());
      tick();
      n++;
    end
    check("dist_latency", n, 10);
    check("dist_pt", o_plain_text, c1_pt);
    check("dist_phase", o_phase, 3'b101);
    for (int i = 0; i < 3; i++) begin
      i_cipher_text = rand128();
      tick();
      flag &= (o_ready === 1'b0) && (o_valid === 1'b1) && (o_plain_text === c1_pt);
    end
    check("dist_no_reaccept", flag, 1'b1);
    i_valid = 1'b0;
    handshake();

    // Reset five cycles after accept
    issue(c1_ct, c1_ks, 3'b101);
    repeat (5) tick();
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", o_valid, 1'b0);
    check("mid_rst_ready", o_ready, 1'b1);
    check("mid_rst_pt", o_plain_text, '0);
    check("mid_rst_phase", o_phase, '0);
    rst_n = 1'b1;
    issue(c1_ct, c1_ks, 3'b011);
    wait_valid(n);
    check("post_rst_latency", n, 10);
    check("post_rst_pt", o_plain_text, c1_pt);
    check("post_rst_phase", o_phase, 3'b011);
    handshake();

    // Back-to-back with i_valid and i_ready held high
    for (int i = 0; i < 4; i++) begin
      b_pt[i] = rand128();
      b_ks[i] = expand(rand128());
      b_ct[i] = aes_enc(b_pt[i], b_ks[i]);
      b_ph[i] = 3'(i + 2);
    end
    k = 0; got = 0; guard = 0;
    i_ready        = 1'b1;
    i_cipher_text  = b_ct[0];
    i_key_schedule = b_ks[0];
    i_phase        = b_ph[0];
    i_valid        = 1'b1;
    while (got < 4 && guard < 100) begin
      was_ready = o_ready;
      tick();
      guard++;
      if (was_ready && i_valid) begin
        acc_at[k] = guard;
        k++;
        if (k < 4) begin
          i_cipher_text  = b_ct[k];
          i_key_schedule = b_ks[k];
          i_phase        = b_ph[k];
        end else begin
          i_valid = 1'b0;
        end
      end
      if (o_valid === 1'b1) begin
        check($sformatf("b2b_pt%0d", got), o_plain_text, b_pt[got]);
        check($sformatf("b2b_phase%0d", got), o_phase, b_ph[got]);
        got++;
      end
    end
    i_valid = 1'b0;
    check("b2b_results", got, 4);
    check("b2b_accepts", k, 4);
    for (int i = 0; i < 3; i++) check($sformatf("b2b_gap%0d", i), acc_at[i+1] - acc_at[i], 12);
    tick();
    i_ready = 1'b0;

    // Random round-trip
    for (int t = 0; t < 1000; t++) begin
      key = rand128();
      ks  = expand(key);
      pt  = rand128();
      ct  = aes_enc(pt, ks);
      issue(ct, ks, 3'(t));
      wait_valid(n);
      check($sformatf("rt%0d", t), o_plain_text, pt);
      handshake();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
